// File: rtl/mole_light_scheduler.sv
// rtl/mole_light_scheduler.sv - whack-a-mole light scheduler with LFSR picks, hit/miss detection and score counters
module mole_light_scheduler #(
    parameter int                N_LIGHTS = 9,
    parameter int                TIMER_W  = 28,
    parameter int                LFSR_W   = 16,
    parameter logic [LFSR_W-1:0] SEED     = 16'h0001,
    parameter int                CNT_W    = 8,
    parameter int                POS_W    = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                load_seed,
    input  logic [LFSR_W-1:0]   seed,
    input  logic [TIMER_W-1:0]  on_time,
    input  logic [TIMER_W-1:0]  gap_time,
    input  logic [N_LIGHTS-1:0] buttons,
    output logic [N_LIGHTS-1:0] lights,
    output logic [POS_W-1:0]    position,
    output logic                hit,
    output logic                miss,
    output logic                active,
    output logic [CNT_W-1:0]    hit_count,
    output logic [CNT_W-1:0]    miss_count
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_GAP  = 2'd1;
    localparam logic [1:0] S_ON   = 2'd2;

    localparam logic [N_LIGHTS-1:0] LIGHT_ONE = {{(N_LIGHTS-1){1'b0}}, 1'b1};
    localparam logic [POS_W-1:0]    LAST_POS  = POS_W'(N_LIGHTS - 1);
    localparam logic [CNT_W-1:0]    CNT_MAX   = '1;

    logic [1:0]          state;
    logic [TIMER_W-1:0]  cnt;
    logic [LFSR_W-1:0]   lfsr;
    logic [N_LIGHTS-1:0] buttons_q;
    logic                have_pick;

    logic                feedback;
    logic [N_LIGHTS-1:0] rise;
    logic                hit_now;
    logic [POS_W-1:0]    raw;
    logic [POS_W-1:0]    raw_next;
    logic [POS_W-1:0]    pick;

    assign active = (state != S_IDLE);

    // Taps for x^16+x^14+x^13+x^11+1 in a left-shifting Fibonacci register
    assign feedback = lfsr[LFSR_W-1] ^ lfsr[LFSR_W-3] ^ lfsr[LFSR_W-4] ^ lfsr[LFSR_W-6];

    // Only a fresh press on the lit position counts; held or foreign buttons are ignored
    assign rise    = buttons & ~buttons_q;
    assign hit_now = rise[position];

    // Position choice: low LFSR byte folded onto the board, bumped by one to avoid an immediate repeat
    always_comb begin
        raw      = POS_W'(lfsr[7:0] % 8'(N_LIGHTS));
        raw_next = (raw == LAST_POS) ? '0 : raw + 1'b1;
        pick     = (have_pick && (raw == position)) ? raw_next : raw;
    end

    // Random source free-runs in every state; a zero seed would lock it up, so fall back to SEED
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lfsr <= SEED;
        end else if (load_seed) begin
            lfsr <= (seed == '0) ? SEED : seed;
        end else begin
            lfsr <= {lfsr[LFSR_W-2:0], feedback};
        end
    end

    // Previous button levels for rising-edge detection
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            buttons_q <= '0;
        end else begin
            buttons_q <= buttons;
        end
    end

    // Game sequencer: IDLE -> GAP -> ON -> GAP ..., with start low forcing a silent return to IDLE
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            cnt        <= '0;
            lights     <= '0;
            position   <= '0;
            have_pick  <= 1'b0;
            hit        <= 1'b0;
            miss       <= 1'b0;
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            hit  <= 1'b0;
            miss <= 1'b0;
            if (!start) begin
                state     <= S_IDLE;
                lights    <= '0;
                have_pick <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        lights     <= '0;
                        have_pick  <= 1'b0;
                        state      <= S_GAP;
                        cnt        <= gap_time;
                        hit_count  <= '0;
                        miss_count <= '0;
                    end
                    S_GAP: begin
                        if (cnt != '0) begin
                            cnt <= cnt - 1'b1;
                        end else begin
                            state     <= S_ON;
                            lights    <= LIGHT_ONE << pick;
                            position  <= pick;
                            have_pick <= 1'b1;
                            cnt       <= on_time;
                        end
                    end
                    S_ON: begin
                        if (hit_now) begin
                            hit    <= 1'b1;
                            lights <= '0;
                            state  <= S_GAP;
                            cnt    <= gap_time;
                            if (hit_count != CNT_MAX) begin
                                hit_count <= hit_count + 1'b1;
                            end
                        end else if (cnt == '0) begin
                            miss   <= 1'b1;
                            lights <= '0;
                            state  <= S_GAP;
                            cnt    <= gap_time;
                            if (miss_count != CNT_MAX) begin
                                miss_count <= miss_count + 1'b1;
                            end
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                    default: begin
                        state  <= S_IDLE;
                        lights <= '0;
                    end
                endcase
            end
        end
    end

endmodule
